trace_processor: RTL and testbench
==================================

# trace_processor

Parametrised trace-driven processor model for the directory-based coherence testbench. It replays a loadable trace of read/write/bubble entries toward one cache controller over a valid/ready request channel. It waits for read responses and checks them against expected data, and reports completion and mismatches. One instance per processor node, selected by `PROC_ID`. It replaces the fixed-table, free-running instruction stubs with a stall-aware, restartable sequencer.

## Interface
- `ADDR_W`, 8, request address width
- `DATA_W`, 8, request/response data width
- `DEPTH`, 16, trace entries (power of two, ≥2); `IDX_W = log2(DEPTH)`
- `LOOP`, 0, 1 = wrap to entry 0 after the last entry until `stop`; 0 = finish once
- `PROC_ID`, 0, node identifier, driven on `req_src`
- Entry format, `ENTRY_W = 3+ADDR_W+DATA_W`: [ENTRY_W-1] bubble, [ENTRY_W-2] op (1 = write, 0 = read), [ENTRY_W-3] chk, then addr, then data (write data, or expected read data)

Ports:
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `load_en` in 1, write `load_entry` into trace memory at `load_idx`
- `load_idx` in IDX_W, trace write index
- `load_entry` in ENTRY_W, trace entry
- `length` in IDX_W+1, number of entries to run (0..DEPTH), sampled on start
- `start` in 1, single-cycle start pulse
- `stop` in 1, request abort at the next entry boundary
- `req_valid` out 1, request present
- `req_ready` in 1, controller accepts request
- `req_op` out 1, 1 = write
- `req_addr` out ADDR_W
- `req_data` out DATA_W
- `req_src` out 8, `PROC_ID`
- `rsp_valid` in 1, read response present
- `rsp_data` in DATA_W
- `busy` out 1, sequencer running
- `done` out 1, run finished (sticky)
- `rd_data` out DATA_W, last captured read data
- `mismatch` out 1, sticky: a chk read returned unexpected data
- `issue_count` out 16, accepted requests since start (wraps mod 2^16)

## Operation
- States: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE → ISSUE on `start` with `length≠0`:
  - ptr←0, len←length.
  - `mismatch`, `issue_count`, stop-pending flag cleared.
- IDLE/DONE → DONE on `start` with `length=0`, with the same clears.
- DONE also accepts `start` (restart).
- `start` in ISSUE/WAIT_RSP is ignored.
- ISSUE, bubble entry: `req_valid`=0 for exactly one cycle, then advance.
- ISSUE, non-bubble entry: `req_valid`=1 with fields from mem[ptr]. Fields stay stable until accepted (`req_valid & req_ready` at an edge).
  - On acceptance, `issue_count`+1.
  - Write: posted, advance.
  - Read: go to WAIT_RSP.
- WAIT_RSP: on `rsp_valid`:
  - `rd_data`←`rsp_data`.
  - If chk=1 and `rsp_data`≠expected data: `mismatch`←1.
  - Then advance.
- `rsp_valid` in any other state is ignored.
- Advance:
  - If stop-pending: → DONE.
  - Else if ptr=len-1: LOOP=0 → DONE; LOOP=1 → ptr←0, ISSUE.
  - Else ptr+1, ISSUE.
- `stop` sets stop-pending in any busy state. An asserted `req_valid` is never withdrawn; stop takes effect only at the next advance.
- `load_en` writes memory only in IDLE/DONE; ignored while busy.
- Load and start in the same cycle: the load is written and the run uses the new contents.
- `busy` = state ∈ {ISSUE, WAIT_RSP}.
- `done` = state is DONE.

## Timing
- Reset, asynchronous:
  - State IDLE.
  - All outputs 0 except `req_src` (constant).
  - ptr, len, stop-pending cleared.
  - Trace memory not reset; contents retained.
- `req_*` and `busy`/`done` depend only on registered state, ptr and memory. There is no combinational path from `req_ready` or `rsp_valid` to any output.
- Start pulse at edge E0 → `req_valid` high in the cycle after E0.
- Writes with `req_ready`=1 held: one request per cycle, back-to-back.
- Reads: acceptance at edge N; earliest `rsp_valid` sampled at edge N+1; next request visible in the cycle after the response edge.
- `done` rises in the cycle after the last advance and holds until `start` or `rst`.
- Reset mid-transaction abandons the outstanding request or read immediately; no further request is issued.

## Test plan
- Load 4 writes (addr 0x10..0x13, data 0xA0..0xA3), `length`=4, `req_ready`=1 → 4 consecutive `req_valid` cycles with matching fields, `issue_count`=4, `done` the next cycle.
- Write, bubble, read (chk=1, expect 0x80); `req_ready` low 3 cycles on the write; `rsp_data`=0x80 two cycles after read acceptance → fields stable while stalled, one idle cycle for the bubble, `rd_data`=0x80, `mismatch`=0.
- Same read with `rsp_data`=0x7F → `mismatch`=1, stays 1 through DONE, cleared by the next `start`.
- LOOP=1, 2 writes, `stop` pulsed while the second write is stalled → that write still completes, then DONE; `issue_count` equals the number of accepted requests.
- `length`=0 start → DONE next cycle, no `req_valid`. `start`/`load_en` while busy → no effect on the run or on memory.
- Assert `rst` in WAIT_RSP → all outputs 0 asynchronously. A later start without reload replays the retained trace.

Source files
------------

// File: rtl/trace_processor.sv
// Trace-driven processor node: replays a loaded trace of read/write/bubble
// entries over a valid/ready request channel, checks read responses against
// expected data, and reports completion, mismatches and accepted requests.
module trace_processor #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int LOOP    = 0,
    parameter int PROC_ID = 0,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int ENTRY_W = 3 + ADDR_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [IDX_W-1:0]   load_idx,
    input  logic [ENTRY_W-1:0] load_entry,
    input  logic [IDX_W:0]     length,
    input  logic               start,
    input  logic               stop,
    output logic               req_valid,
    input  logic               req_ready,
    output logic               req_op,
    output logic [ADDR_W-1:0]  req_addr,
    output logic [DATA_W-1:0]  req_data,
    output logic [7:0]         req_src,
    input  logic               rsp_valid,
    input  logic [DATA_W-1:0]  rsp_data,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  rd_data,
    output logic               mismatch,
    output logic [15:0]        issue_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W:0]       r_len;
    logic                 r_stop_pend;
    logic [DATA_W-1:0]    r_rd_data;
    logic                 r_mismatch;
    logic [15:0]          r_issue_cnt;

    logic [ENTRY_W-1:0]   w_entry;
    logic                 w_bubble;
    logic                 w_op;
    logic                 w_chk;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_data;
    logic                 w_busy;
    logic                 w_last;
    logic                 w_start_ok;
    logic                 w_adv;
    logic                 w_accept;
    logic                 w_rsp_take;
    logic                 w_req_valid;

    assign w_entry     = r_mem[r_ptr];
    assign w_bubble    = w_entry[ENTRY_W-1];
    assign w_op        = w_entry[ENTRY_W-2];
    assign w_chk       = w_entry[ENTRY_W-3];
    assign w_addr      = w_entry[DATA_W +: ADDR_W];
    assign w_data      = w_entry[DATA_W-1:0];
    assign w_busy      = (r_state == S_ISSUE) || (r_state == S_WAIT_RSP);
    assign w_last      = ({1'b0, r_ptr} == (r_len - 1'b1));
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_req_valid = (r_state == S_ISSUE) && !w_bubble;

    // Request fields are gated by valid so that reset drives them to zero
    // regardless of what the retained trace memory holds at entry 0.
    assign req_valid   = w_req_valid;
    assign req_op      = w_req_valid ? w_op   : 1'b0;
    assign req_addr    = w_req_valid ? w_addr : '0;
    assign req_data    = w_req_valid ? w_data : '0;
    assign req_src     = 8'(PROC_ID);
    assign busy        = w_busy;
    assign done        = (r_state == S_DONE);
    assign rd_data     = r_rd_data;
    assign mismatch    = r_mismatch;
    assign issue_count = r_issue_cnt;

    // Next-state decode; an advance resolves to DONE, wrap or next entry.
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_accept    = 1'b0;
        w_rsp_take  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = (length != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (w_bubble) begin
                    w_adv = 1'b1;
                end else if (req_ready) begin
                    w_accept = 1'b1;
                    if (w_op) begin
                        w_adv = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_RSP;
                    end
                end
            end
            S_WAIT_RSP: begin
                if (rsp_valid) begin
                    w_rsp_take = 1'b1;
                    w_adv      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_adv) begin
            if (r_stop_pend || stop) begin
                w_state_nxt = S_DONE;
            end else if (w_last && (LOOP == 0)) begin
                w_state_nxt = S_DONE;
            end else begin
                w_state_nxt = S_ISSUE;
            end
        end
    end

    // Sequencer state, pointer, counters and sticky status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_len       <= '0;
            r_stop_pend <= 1'b0;
            r_rd_data   <= '0;
            r_mismatch  <= 1'b0;
            r_issue_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_ptr       <= '0;
                r_len       <= length;
                r_stop_pend <= 1'b0;
                r_mismatch  <= 1'b0;
                r_issue_cnt <= '0;
            end else begin
                if (w_accept) begin
                    r_issue_cnt <= r_issue_cnt + 16'd1;
                end
                if (stop && w_busy) begin
                    r_stop_pend <= 1'b1;
                end
                if (w_adv) begin
                    r_ptr <= w_last ? '0 : r_ptr + 1'b1;
                end
                if (w_rsp_take) begin
                    r_rd_data <= rsp_data;
                    if (w_chk && (rsp_data != w_data)) begin
                        r_mismatch <= 1'b1;
                    end
                end
            end
        end
    end

    // Trace memory is not reset so a trace survives rst and can be replayed.
    always_ff @(posedge clk) begin
        if (load_en && !w_busy) begin
            r_mem[load_idx] <= load_entry;
        end
    end

endmodule

// File: tb/tb_trace_processor.sv
// Directed bench for trace_processor: one finite-run node and one looping node.
module tb_trace_processor;

    localparam int EW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [3:0]    load_idx;
    logic [EW-1:0] load_entry;
    logic [4:0]    length;
    logic          start, stop, start_l, stop_l;
    logic          req_ready, rsp_valid;
    logic [7:0]    rsp_data;

    logic          req_valid, req_op, busy, done, mismatch;
    logic [7:0]    req_addr, req_data, req_src, rd_data;
    logic [15:0]   issue_count;

    logic          l_req_valid, l_req_op, l_busy, l_done, l_mismatch;
    logic [7:0]    l_req_addr, l_req_data, l_req_src, l_rd_data;
    logic [15:0]   l_issue_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trace_processor #(.LOOP(0), .PROC_ID(3)) u_dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx),
        .load_entry(load_entry), .length(length), .start(start), .stop(stop),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_src(req_src),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .done(done),
        .rd_data(rd_data), .mismatch(mismatch), .issue_count(issue_count)
    );

    trace_processor #(.LOOP(1), .PROC_ID(5)) u_loop (
        .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx),
        .load_entry(load_entry), .length(length), .start(start_l), .stop(stop_l),
        .req_valid(l_req_valid), .req_ready(req_ready), .req_op(l_req_op),
        .req_addr(l_req_addr), .req_data(l_req_data), .req_src(l_req_src),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(l_busy), .done(l_done),
        .rd_data(l_rd_data), .mismatch(l_mismatch), .issue_count(l_issue_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic b, input logic op, input logic c,
                                         input logic [7:0] a, input logic [7:0] d);
        return {b, op, c, a, d};
    endfunction

    task automatic load(input int idx, input logic [EW-1:0] e);
        load_idx   = 4'(idx);
        load_entry = e;
        load_en    = 1'b1;
        @(negedge clk);
        load_en    = 1'b0;
    endtask

    task automatic go(input int len);
        length = 5'(len);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_en = 0; load_idx = 0; load_entry = 0; length = 0;
        start = 0; stop = 0; start_l = 0; stop_l = 0;
        req_ready = 0; rsp_valid = 0; rsp_data = 0;
        repeat (2) @(negedge clk);

        // reset state
        check_eq("rst_valid", req_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cnt", issue_count, 0);
        check_eq("rst_src", req_src, 3);
        rst = 1'b0;
        @(negedge clk);

        // four back-to-back writes
        for (int i = 0; i < 4; i++) load(i, mk(0, 1, 0, 8'(8'h10 + i), 8'(8'hA0 + i)));
        req_ready = 1'b1;
        go(4);
        for (int i = 0; i < 4; i++) begin
            check_eq("wr_valid", req_valid, 1);
            check_eq("wr_op", req_op, 1);
            check_eq("wr_addr", req_addr, 32'h10 + i);
            check_eq("wr_data", req_data, 32'hA0 + i);
            @(negedge clk);
        end
        check_eq("wr_done", done, 1);
        check_eq("wr_busy", busy, 0);
        check_eq("wr_valid_end", req_valid, 0);
        check_eq("wr_cnt", issue_count, 4);

        // write stalled, bubble, checked read with correct data
        load(0, mk(0, 1, 0, 8'h20, 8'h55));
        load(1, mk(1, 0, 0, 8'h00, 8'h00));
        load(2, mk(0, 0, 1, 8'h30, 8'h80));
        req_ready = 1'b0;
        go(3);
        for (int k = 0; k < 3; k++) begin
            check_eq("stall_valid", req_valid, 1);
            check_eq("stall_addr", req_addr, 32'h20);
            check_eq("stall_data", req_data, 32'h55);
            @(negedge clk);
        end
        check_eq("stall_hold", req_addr, 32'h20);
        req_ready = 1'b1;
        @(negedge clk);
        check_eq("bubble_valid", req_valid, 0);
        check_eq("bubble_busy", busy, 1);
        @(negedge clk);
        check_eq("rd_valid", req_valid, 1);
        check_eq("rd_op", req_op, 0);
        check_eq("rd_addr", req_addr, 32'h30);
        @(negedge clk);
        check_eq("wait_valid", req_valid, 0);
        check_eq("wait_busy", busy, 1);
        @(negedge clk);
        rsp_valid = 1'b1; rsp_data = 8'h80;
        @(negedge clk);
        rsp_valid = 1'b0;
        check_eq("rd_done", done, 1);
        check_eq("rd_data", rd_data, 32'h80);
        check_eq("rd_mismatch", mismatch, 0);
        check_eq("rd_cnt", issue_count, 2);

        // same read with wrong data -> sticky mismatch, cleared by start
        go(3);
        repeat (3) @(negedge clk);
        rsp_valid = 1'b1; rsp_data = 8'h7F;
        @(negedge clk);
        rsp_valid = 1'b0;
        check_eq("mm_done", done, 1);
        check_eq("mm_flag", mismatch, 1);
        check_eq("mm_rd_data", rd_data, 32'h7F);
        repeat (3) @(negedge clk);
        check_eq("mm_sticky", mismatch, 1);
        go(0);
        check_eq("len0_done", done, 1);
        check_eq("len0_valid", req_valid, 0);
        check_eq("len0_mm_clr", mismatch, 0);
        check_eq("len0_cnt", issue_count, 0);

        // start and load while busy are ignored
        req_ready = 1'b0;
        go(3);
        check_eq("busy_valid0", req_valid, 1);
        length = 5'd0; start = 1'b1;
        load_idx = 4'd0; load_entry = mk(0, 1, 0, 8'hEE, 8'hEE); load_en = 1'b1;
        @(negedge clk);
        start = 1'b0; load_en = 1'b0;
        check_eq("busy_ign_valid", req_valid, 1);
        check_eq("busy_ign_addr", req_addr, 32'h20);
        check_eq("busy_ign_busy", busy, 1);
        req_ready = 1'b1;
        @(negedge clk);
        check_eq("busy_cnt1", issue_count, 1);
        @(negedge clk);
        check_eq("busy_rd_addr", req_addr, 32'h30);
        @(negedge clk);
        rsp_valid = 1'b1; rsp_data = 8'h80;
        @(negedge clk);
        rsp_valid = 1'b0;
        check_eq("busy_done", done, 1);
        check_eq("busy_mm", mismatch, 0);
        check_eq("busy_cnt2", issue_count, 2);

        // reset while waiting for a read response, then replay retained trace
        go(3);
        repeat (3) @(negedge clk);
        check_eq("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_valid", req_valid, 0);
        check_eq("arst_cnt", issue_count, 0);
        check_eq("arst_rd_data", rd_data, 0);
        check_eq("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_idle", req_valid, 0);
        go(3);
        check_eq("replay_valid", req_valid, 1);
        check_eq("replay_addr", req_addr, 32'h20);
        check_eq("replay_data", req_data, 32'h55);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // looping node: wrap, then stop while second write is stalled
        load(0, mk(0, 1, 0, 8'h40, 8'h11));
        load(1, mk(0, 1, 0, 8'h41, 8'h22));
        req_ready = 1'b1;
        length = 5'd2; start_l = 1'b1;
        @(negedge clk);
        start_l = 1'b0;
        check_eq("loop_a0", l_req_addr, 32'h40);
        @(negedge clk);
        check_eq("loop_a1", l_req_addr, 32'h41);
        @(negedge clk);
        check_eq("loop_wrap", l_req_addr, 32'h40);
        check_eq("loop_busy", l_busy, 1);
        @(negedge clk);
        check_eq("loop_a1b", l_req_addr, 32'h41);
        req_ready = 1'b0; stop_l = 1'b1;
        @(negedge clk);
        stop_l = 1'b0;
        check_eq("stop_hold_valid", l_req_valid, 1);
        check_eq("stop_hold_addr", l_req_addr, 32'h41);
        req_ready = 1'b1;
        @(negedge clk);
        check_eq("stop_done", l_done, 1);
        check_eq("stop_valid", l_req_valid, 0);
        check_eq("stop_cnt", l_issue_count, 4);
        @(negedge clk);
        check_eq("stop_done_hold", l_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
